cr_iu_icache_inv_ctrl: RTL
==========================

Name: cr_iu_icache_inv_ctrl

Overview:
Sequencer for instruction-cache maintenance (fence.i, icache invalidate-all, icache invalidate-by-PA) issued by the IU special unit. Latches the request and waits for outstanding stores to drain. It then walks the icache index space, or hits one index for by-PA, issuing one invalidate per cycle under a req/ack handshake. Completion is returned to the special unit as a level "done" held under a 4-phase handshake; sits between the IU special unit and the icache invalidate port.

Parameters:
INDEX_W, 7, icache set-index width (2^INDEX_W sets)
LINE_OFF, 4, log2 of line size in bytes; index = addr[LINE_OFF+INDEX_W-1:LINE_OFF]

Ports:
forever_cpuclk  input  1  core clock
cpurst_b  input  1  asynchronous active-low reset
iu_inv_req  input  1  level request from special unit; held until inv_iu_done seen
iu_inv_type  input  2  00 fence.i, 01 icall (inv all), 10 icpa (inv by PA), 11 reserved (treated as 01)
iu_inv_addr  input  32  physical address for icpa; sampled on acceptance
iu_inv_flush  input  1  pipeline flush/abort from IU
wb_inv_st_uncmplt  input  1  stores outstanding in WB/store path
cp0_icache_en  input  1  icache enabled
inv_icache_req  output  1  invalidate request for one set index
inv_icache_index  output  INDEX_W  set index being invalidated
icache_inv_ack  input  1  icache accepted current request this cycle
inv_iu_done  output  1  operation complete (drives special-unit cache_inv_done)
inv_iu_busy  output  1  controller not idle

Behaviour:
- Reset (cpurst_b low, async): state IDLE, index counter 0, type/index latches 0; all outputs 0.
- States: IDLE, DRAIN, WALK, DONE. Registered state; outputs decoded from state (Moore).
- IDLE: inv_iu_busy=0, inv_iu_done=0. On iu_inv_req=1 and iu_inv_flush=0: latch type. Index = 0 for fence.i/icall/reserved, or iu_inv_addr[LINE_OFF+INDEX_W-1:LINE_OFF] for icpa. Go to DRAIN. The cycle the request is first seen is accept; busy rises the next cycle.
- DRAIN: wait for wb_inv_st_uncmplt=0.
  - If iu_inv_flush=1: go to IDLE (drop request); flush has priority over drain completion in the same cycle.
  - Drained with cp0_icache_en=0: go to DONE (no walk).
  - Drained with cp0_icache_en=1: go to WALK.
- WALK: inv_icache_req=1, inv_icache_index = counter; req and index stable until ack.
  - On icache_inv_ack: icpa -> DONE; otherwise, if counter == 2^INDEX_W-1 -> DONE, else counter+1 and stay in WALK.
  - Back-to-back acks give one index per cycle; full walk takes exactly 2^INDEX_W ack cycles.
  - iu_inv_flush ignored in WALK; the walk always completes.
  - cp0_icache_en changes ignored once in WALK.
- DONE: inv_iu_done=1, inv_icache_req=0. Stay until iu_inv_req=0 or iu_inv_flush=1, then IDLE with counter cleared to 0. No new request is accepted in the same cycle DONE exits.
- inv_iu_busy = state != IDLE.
- inv_iu_done is 0 in all states except DONE. Special unit stalls while done=0, so a request held across DRAIN/WALK stalls the IU.
- Counter wrap: never increments past 2^INDEX_W-1; no wrap to 0 inside WALK.
- Request deasserted mid-DRAIN without flush is a protocol violation; the controller continues to DONE and exits when it sees req=0.

Test Plan:
- fence.i, no stores pending, icache enabled, ack tied 1 (INDEX_W=7): inv_icache_req high 128 consecutive cycles, index 0..127. inv_iu_done rises the cycle after index 127 acked; drop req -> busy=0 next cycle.
- icpa addr=0x0000_1A30, LINE_OFF=4: single request with index 0x23, then DONE; exactly one req cycle.
- wb_inv_st_uncmplt high 5 cycles after accept: no inv_icache_req during those cycles; first req the cycle after uncmplt falls.
- iu_inv_flush in DRAIN -> IDLE, no req ever issued, done stays 0.
- iu_inv_flush during WALK at index 40 -> walk continues to 127, done asserted.
- cp0_icache_en=0 fence.i -> DONE directly after drain, zero reqs.
- Ack stalled (icache_inv_ack=0 for 3 cycles at index 10) -> index holds 10, req held high.
- cpurst_b low mid-walk at index 60 -> req=0, done=0, busy=0 immediately; after release a new request restarts at index 0.

Source files
------------

// File: rtl/cr_iu_icache_inv_ctrl_if.sv
// Signal bundle between the IU special unit / icache invalidate port and the
// icache invalidate sequencer. "slave" is the sequencer, "master" its environment.
interface cr_iu_icache_inv_ctrl_if #(
  parameter int INDEX_W = 7
);
  logic               iu_inv_req;
  logic [1:0]         iu_inv_type;
  logic [31:0]        iu_inv_addr;
  logic               iu_inv_flush;
  logic               wb_inv_st_uncmplt;
  logic               cp0_icache_en;
  logic               inv_icache_req;
  logic [INDEX_W-1:0] inv_icache_index;
  logic               icache_inv_ack;
  logic               inv_iu_done;
  logic               inv_iu_busy;

  modport slave (
    input  iu_inv_req, iu_inv_type, iu_inv_addr, iu_inv_flush,
    input  wb_inv_st_uncmplt, cp0_icache_en, icache_inv_ack,
    output inv_icache_req, inv_icache_index, inv_iu_done, inv_iu_busy
  );

  modport master (
    output iu_inv_req, iu_inv_type, iu_inv_addr, iu_inv_flush,
    output wb_inv_st_uncmplt, cp0_icache_en, icache_inv_ack,
    input  inv_icache_req, inv_icache_index, inv_iu_done, inv_iu_busy
  );
endinterface

// File: rtl/cr_iu_icache_inv_ctrl.sv
// Icache maintenance sequencer: drains stores, then invalidates one set
// (by-PA) or every set (fence.i / inv-all) and reports a 4-phase done.
module cr_iu_icache_inv_ctrl #(
  parameter int INDEX_W  = 7,
  parameter int LINE_OFF = 4
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst_b,
  cr_iu_icache_inv_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WALK  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0]         TYPE_ICALL = 2'b01;
  localparam logic [1:0]         TYPE_ICPA  = 2'b10;
  localparam logic [1:0]         TYPE_RSVD  = 2'b11;
  localparam logic [INDEX_W-1:0] IDX_LAST   = {INDEX_W{1'b1}};

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic [1:0]         type_q, type_d;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iu_inv_req && !bus.iu_inv_flush) begin
          // Reserved encoding behaves as invalidate-all.
          type_d  = (bus.iu_inv_type == TYPE_RSVD) ? TYPE_ICALL : bus.iu_inv_type;
          cnt_d   = (bus.iu_inv_type == TYPE_ICPA)
                    ? bus.iu_inv_addr[LINE_OFF+INDEX_W-1:LINE_OFF] : '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.iu_inv_flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (!bus.wb_inv_st_uncmplt) begin
          state_d = bus.cp0_icache_en ? ST_WALK : ST_DONE;
        end
      end
      ST_WALK: begin
        // Flush is deliberately ignored here: a partial walk would leave stale lines.
        if (bus.icache_inv_ack) begin
          if (type_q == TYPE_ICPA || cnt_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!bus.iu_inv_req || bus.iu_inv_flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.inv_icache_req   = (state_q == ST_WALK);
  assign bus.inv_icache_index = cnt_q;
  assign bus.inv_iu_done      = (state_q == ST_DONE);
  assign bus.inv_iu_busy      = (state_q != ST_IDLE);

endmodule
